// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO front end that feeds one byte at a time to the UART transmitter.
// It buffers host bytes in a DEPTH-entry FIFO. newd is held for one bit period.
// Each frame ends on a donetx rising edge, or on a timeout.
//
// Ports:
//   clk, rst       : rising-edge clock; asynchronous active-low reset
//   wr_data, wr_en : enqueue port, one byte per cycle
//   full, empty    : FIFO status, registered
//   count          : FIFO occupancy, 0..DEPTH
//   overflow       : one-cycle pulse after a write arrives while the FIFO is full
//   dintx, newd    : byte and start request to the transmitter
//   donetx         : frame-complete from the transmitter; may be slow or held high
//   busy           : the FSM is not idle
//   tx_err         : sticky flag set when donetx never came; cleared only by reset

module uart_tx_feeder #(
    parameter int CLK_FREQ     = 1000000,
    parameter int BAUD         = 9600,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        dintx,
    output logic              newd,
    input  logic              donetx,
    output logic              busy,
    output logic              tx_err
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int TO_CYC  = TIMEOUT_BITS * BIT_CYC;
    localparam int CNT_W   = $clog2(TO_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0]  TO_LD   = CNT_W'(TO_CYC - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT1    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    // ---------------- FIFO storage and pointers ----------------
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;

    // ---------------- FSM state ----------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        dintx_q, dintx_d;
    logic              newd_q, newd_d;
    logic              err_q, err_d;
    logic              done_q;

    logic              wr_acc;
    logic              pop;
    logic              done_rise;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign dintx    = dintx_q;
    assign newd     = newd_q;
    assign busy     = (state_q != S_IDLE);
    assign tx_err   = err_q;

    // Acceptance uses the registered full flag. A pop in the same cycle does not make room.
    assign wr_acc    = wr_en && !full;
    assign done_rise = donetx && !done_q;

    // Storage has no reset. Reset empties the FIFO, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = wr_en && full;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT1;
            2'b01:   count_d = count_q - CNT1;
            default: count_d = count_q;
        endcase
    end

    // One down-counter serves as the newd hold timer in SEND.
    // It then serves as the donetx timeout in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dintx_d = dintx_q;
        newd_d  = newd_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    dintx_d = mem_q[rd_ptr_q];
                    newd_d  = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == '0) begin
                    newd_d  = 1'b0;
                    cnt_d   = TO_LD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT: begin
                if (done_rise) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                newd_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dintx_q  <= 8'h00;
            newd_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dintx_q  <= dintx_d;
            newd_q   <= newd_d;
            err_q    <= err_d;
            done_q   <= donetx;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks of uart_tx_feeder.
// It uses a queue-based byte model and a behavioural transmitter responder.

module tb_uart_tx_feeder;

    localparam int BIT_CYC = 104;
    localparam int TO_TOT  = BIT_CYC + 12 * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       full, empty, overflow, newd, busy, tx_err;
    logic [4:0] count;
    logic [7:0] dintx;
    logic       donetx;

    // 0: bench drives donetx by hand; 1: pulse 10 bit periods after newd rises;
    // 2: pulse a short random time after newd falls
    int         tx_mode = 0;
    logic       man_done = 1'b0;
    logic       mdl_done = 1'b0;

    assign donetx = (tx_mode == 0) ? man_done : mdl_done;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] obs[$];
    logic [7:0] exp_q[$];
    int         obs_base = 0;
    int         bad_w = 0;
    int         nhigh = 0;
    logic       newd_seen = 1'b0;
    logic       armed = 1'b0;
    int         dcnt = 0;

    always #5 clk = ~clk;

    uart_tx_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .dintx    (dintx),
        .newd     (newd),
        .donetx   (donetx),
        .busy     (busy),
        .tx_err   (tx_err)
    );

    // Transmitter responder and frame monitor
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (!rst) begin
            armed     = 1'b0;
            newd_seen = 1'b0;
            nhigh     = 0;
        end else begin
            if (armed) begin
                if (dcnt == 0) begin
                    mdl_done = 1'b1;
                    armed    = 1'b0;
                end else begin
                    dcnt--;
                end
            end
            if (newd && !newd_seen) begin
                obs.push_back(dintx);
                nhigh = 1;
                if (tx_mode == 1) begin
                    armed = 1'b1;
                    dcnt  = 10 * BIT_CYC - 2;
                end
            end else if (newd) begin
                nhigh++;
            end
            if (!newd && newd_seen) begin
                if (nhigh != BIT_CYC) bad_w++;
                if (tx_mode == 2) begin
                    armed = 1'b1;
                    dcnt  = int'($urandom_range(40, 0));
                end
            end
            newd_seen = newd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr1(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ticks(3);
        rst = 1'b1;
        tick();
        exp_q.delete();
        obs_base = obs.size();
        bad_w    = 0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k;
        k = 0;
        while ((obs.size() - obs_base) < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || !empty) && k < budget) begin
            tick();
            k++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic cmp_seq(input string tag);
        int n;
        n = obs.size() - obs_base;
        chk({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk(tag, obs[obs_base + i], exp_q[i]);
        end
    endtask

    initial begin
        int         hi;
        int         ovf_n;
        int         wn;
        int         guard;
        int         ob;
        logic [7:0] b;

        // Reset values
        ticks(5);
        chk("rst_dintx", dintx, 0);
        chk("rst_newd", newd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        rst = 1'b1;
        tick();

        // First byte latency and newd width
        wr1(8'hA5);
        chk("lat_empty", empty, 0);
        chk("lat_newd0", newd, 0);
        tick();
        chk("lat_newd1", newd, 1);
        chk("lat_dintx", dintx, 8'hA5);
        chk("lat_busy", busy, 1);
        hi = 1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (newd) hi++;
            else break;
        end
        chk("newd_width", hi, BIT_CYC);

        // Ordering with a transmitter replying 10 bit periods after newd
        do_reset();
        tx_mode = 1;
        for (int i = 0; i < 16; i++) begin
            wr1(8'(i + 1));
            chk("burst_count", count, (i == 0) ? 1 : i);
            chk("burst_full", full, 0);
        end
        wait_obs(16, 16 * 1300);
        cmp_seq("order");
        wait_idle(1500);
        chk("order_empty", empty, 1);
        chk("order_width", bad_w, 0);

        // Overflow with donetx stalled
        do_reset();
        tx_mode  = 0;
        man_done = 1'b0;
        ovf_n    = 0;
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            if (i < 17) exp_q.push_back(wr_data);
            tick();
            if (overflow) ovf_n++;
            chk("ovf_step", overflow, (i == 17) ? 1 : 0);
        end
        wr_en = 1'b0;
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 16);
        tick();
        chk("ovf_clear", overflow, 0);
        chk("ovf_pulses", ovf_n, 1);
        tx_mode = 2;
        wait_obs(17, 17 * 400);
        cmp_seq("ovf_order");
        wait_idle(1500);
        chk("ovf_width", bad_w, 0);

        // Simultaneous write and pop, then sustained random flow
        do_reset();
        tx_mode  = 0;
        man_done = 1'b0;
        for (int i = 0; i < 6; i++) wr1(8'($urandom));
        chk("sim_count_pre", count, 5);
        ticks(110);
        chk("sim_wait_busy", busy, 1);
        chk("sim_wait_newd", newd, 0);
        man_done = 1'b1;
        tick();
        chk("sim_idle", busy, 0);
        chk("sim_count_idle", count, 5);
        man_done = 1'b0;
        wr1(8'($urandom));
        chk("sim_count_post", count, 5);
        chk("sim_newd", newd, 1);
        chk("sim_dintx", dintx, exp_q[1]);
        tx_mode = 2;
        wn      = 0;
        guard   = 0;
        while (wn < 40 && guard < 20000) begin
            if ($urandom_range(1, 0) == 1 &&
                (exp_q.size() - (obs.size() - obs_base)) < 12) begin
                b = 8'($urandom);
                wr1(b);
                wn++;
            end else begin
                tick();
            end
            guard++;
        end
        chk("wrap_writes", wn, 40);
        wait_obs(exp_q.size(), 20000);
        cmp_seq("wrap");
        wait_idle(1500);
        chk("wrap_count", count, 0);
        chk("wrap_width", bad_w, 0);

        // Timeout when donetx never arrives
        do_reset();
        tx_mode  = 0;
        man_done = 1'b0;
        wr1(8'h3C);
        wr1(8'h3D);
        ticks(TO_TOT - 1);
        chk("to_err_early", tx_err, 0);
        chk("to_busy_early", busy, 1);
        chk("to_dintx_early", dintx, 8'h3C);
        tick();
        chk("to_err", tx_err, 1);
        chk("to_idle", busy, 0);
        tick();
        chk("to_next_newd", newd, 1);
        chk("to_next_dintx", dintx, 8'h3D);
        chk("to_sticky", tx_err, 1);

        // donetx held high completes only one frame
        do_reset();
        tx_mode  = 0;
        man_done = 1'b0;
        wr1(8'h11);
        wr1(8'h22);
        wr1(8'h33);
        ticks(110);
        man_done = 1'b1;
        ticks(3);
        chk("hold_dintx2", dintx, 8'h22);
        chk("hold_newd2", newd, 1);
        ticks(300);
        chk("hold_busy", busy, 1);
        chk("hold_frames", obs.size() - obs_base, 2);
        chk("hold_dintx_kept", dintx, 8'h22);
        man_done = 1'b0;
        tick();
        man_done = 1'b1;
        ticks(3);
        chk("hold_dintx3", dintx, 8'h33);
        chk("hold_newd3", newd, 1);
        chk("hold_err", tx_err, 0);
        man_done = 1'b0;

        // Reset during SEND with bytes queued
        do_reset();
        tx_mode = 0;
        for (int i = 0; i < 8; i++) wr1(8'(8'h40 + i));
        ticks(10);
        chk("mid_newd", newd, 1);
        chk("mid_count", count, 7);
        rst = 1'b0;
        #1;
        chk("mid_rst_newd", newd, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dintx", dintx, 0);
        tick();
        rst = 1'b1;
        tick();
        ob = obs.size();
        ticks(300);
        chk("mid_no_send", obs.size(), ob);
        chk("mid_newd_after", newd, 0);
        chk("mid_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end for the UART transmitter in `uart_top`. It absorbs bursts of host bytes into a DEPTH-entry FIFO and hands them to the transmitter one frame at a time over the `dintx`/`newd`/`donetx` handshake. It sits directly upstream of `uart_top`: its `dintx`/`newd` outputs drive the transmitter inputs of the same names, and it consumes `donetx`.

## Interface
- `CLK_FREQ`, 1000000: system clock frequency in Hz.
- `BAUD`, 9600: line rate. `BIT_CYC = CLK_FREQ/BAUD` (integer divide; 104 at defaults).
- `DEPTH`, 16: FIFO entries. Must be a power of two and ≥2.
- `ADDR_W`, 4: equal to log2(DEPTH).
- `TIMEOUT_BITS`, 12: number of bit periods to wait for `donetx` before declaring a fault.
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `wr_data`, in, 8: byte to enqueue.
- `wr_en`, in, 1: enqueue strobe, one byte per cycle.
- `full`, out, 1: FIFO holds DEPTH entries.
- `empty`, out, 1: FIFO holds 0 entries.
- `count`, out, ADDR_W+1: current occupancy, 0..DEPTH.
- `overflow`, out, 1: one-cycle pulse when a write is dropped.
- `dintx`, out, 8: byte presented to the transmitter.
- `newd`, out, 1: start request to the transmitter.
- `donetx`, in, 1: transmitter frame-complete indication. May be slow or multi-cycle.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `tx_err`, out, 1: sticky timeout flag, cleared only by reset.

## Operation
- **FIFO**
  - Circular buffer with ADDR_W-bit read and write pointers; pointers wrap modulo DEPTH.
  - `count` is a separate register.
  - A write is accepted iff `wr_en && !full`, where `full` is the registered value.
  - A write attempted while `full` is dropped: `overflow` = 1 for the next cycle, and FIFO contents are unchanged.
  - A pop occurs only from the FSM in IDLE, and only when `!empty`.
  - Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
  - A write into an empty FIFO is never bypassed; the byte always passes through storage.
- **FSM** (states IDLE, SEND, WAIT_DONE)
  - IDLE → SEND when `!empty`. In the same edge: pop the head into the `dintx` register, set `newd` = 1, and load the hold counter with BIT_CYC−1.
  - SEND: `newd` stays 1 while the counter decrements. When it reaches 0: `newd` = 0, load the timeout counter with TIMEOUT_BITS*BIT_CYC−1, and go to WAIT_DONE. `newd` is therefore high for exactly BIT_CYC cycles, which guarantees the transmitter's baud-rate sampler sees it.
  - WAIT_DONE → IDLE on a rising edge of `donetx`. The edge is detected against a registered copy of `donetx`; a level held high does not retrigger.
  - WAIT_DONE → IDLE with `tx_err` = 1 if the timeout counter reaches 0 first.
  - `dintx` holds its value until the next pop.
- **Reset (`rst` = 0, any time, including mid-frame)**
  - Pointers, `count`, and all counters go to 0; state goes to IDLE.
  - Outputs: `dintx` = 0, `newd` = 0, `busy` = 0, `overflow` = 0, `tx_err` = 0, `empty` = 1, `full` = 0.
  - Buffered bytes are discarded.
  - Release is synchronous to the next `clk` edge after `rst` goes high.

## Timing
- `full`, `empty`, and `count` update on the edge that accepts the write or pop (registered outputs).
- Latency from write to start, with the FIFO empty and the FSM in IDLE:
  - Write accepted at edge N.
  - `empty` = 0 after edge N.
  - Pop occurs at edge N+1, so `newd` = 1 and `dintx` is valid after N+1.
- `newd` falls after edge N+1+BIT_CYC.
- Back-to-back frames: the next pop occurs on the edge after the `donetx` rising edge is detected, which is 2 cycles after `donetx` rises at the pin.
- `busy` = (state ≠ IDLE). It rises together with `newd`.

## Test plan
- **Reset values:** hold `rst` = 0 for 5 cycles → all outputs at their reset values. Then write 0xA5 → `newd` rises exactly 2 edges after the write, with `dintx` = 0xA5, and stays high for 104 cycles.
- **Ordering and sustained flow:** burst-write 0x01..0x10 on 16 consecutive cycles, with a behavioural transmitter model pulsing `donetx` 10 bit periods after each `newd` → bytes appear on `dintx` in order 0x01..0x10. While the burst is still filling, `full` = 1 only if occupancy reaches 16, and `empty` = 1 after the last pop.
- **Overflow:** stall `donetx` and write 18 bytes (1 is popped) → `full` = 1 with `count` = 16, one `overflow` pulse, and the dropped byte never reaches `dintx`.
- **Simultaneous write and pop:** write on the same edge as a pop with `count` = 5 → `count` stays 5. Pointer wrap: after 40 total transfers, data order is still correct.
- **Timeout and edge detection:** never assert `donetx` → after 104 + 12·104 cycles `tx_err` = 1 and the FSM returns to IDLE, then starts the next byte. Hold `donetx` high continuously → only one frame completes per rising edge.
- **Reset mid-operation:** assert `rst` = 0 during SEND with 7 bytes queued → `newd` drops immediately, `count` = 0, and no further bytes are sent after release.
